// File: rtl/flappy_pkg.sv
// Shared types, default geometry and helpers for the Flappy scoring datapath.
package flappy_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} judge_state_t;

  localparam int ROW_W    = 4;
  localparam int COL_W    = 4;
  localparam int GAP_W    = 3;
  localparam int BIRD_COL = 8;

  // Supports up to 32 channels; the result never exceeds 32.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gap_check.sv
// Combinational test of whether the bird row lies inside one pipe's open gap.
module gap_check #(
  parameter int ROW_W = 4,
  parameter int GAP_W = 3
) (
  input  logic [ROW_W-1:0] bird_pos,
  input  logic [ROW_W-1:0] gap_base,
  input  logic [GAP_W-1:0] gap_size,
  output logic             clear
);

  // One extra bit so gap_base + gap_size cannot wrap at the top of the frame.
  localparam int SUM_W = ((ROW_W > GAP_W) ? ROW_W : GAP_W) + 1;

  logic [SUM_W-1:0] bird_ext;
  logic [SUM_W-1:0] base_ext;
  logic [SUM_W-1:0] top_ext;

  assign bird_ext = SUM_W'(bird_pos);
  assign base_ext = SUM_W'(gap_base);
  assign top_ext  = base_ext + SUM_W'(gap_size);

  // An empty gap fails naturally: no row satisfies base <= bird < base.
  assign clear = (bird_ext >= base_ext) && (bird_ext < top_ext);

endmodule

// File: rtl/pipe_judge.sv
// Scoring/collision judge: play/over FSM, once-per-pipe judgement, saturating score.
// Optional best-score register enabled by defining PIPE_JUDGE_BEST_SCORE_EN.
module pipe_judge
  import flappy_pkg::*;
#(
  parameter int NUM_PIPES = 2,
  parameter int ROW_W     = flappy_pkg::ROW_W,
  parameter int GAP_W     = flappy_pkg::GAP_W,
  parameter int COL_W     = flappy_pkg::COL_W,
  parameter int BIRD_COL  = flappy_pkg::BIRD_COL,
  parameter int SCORE_W   = 8
) (
  input  logic                                                  clock,
  input  logic                                                  reset,
  input  logic                                                  start,
  input  logic [ROW_W-1:0]                                      bird_pos,
  input  logic                                                  OFB,
  input  logic [NUM_PIPES*COL_W-1:0]                            pipe_col,
  input  logic [NUM_PIPES*ROW_W-1:0]                            gap_base,
  input  logic [NUM_PIPES*GAP_W-1:0]                            gap_size,
  output logic                                                  increment,
  output logic                                                  game_over,
  output logic [SCORE_W-1:0]                                    score,
  output logic [((NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1)-1:0]  hit_pipe,
  output logic [SCORE_W-1:0]                                    best_score
);

  localparam int HIT_W = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  judge_state_t state;
  judge_state_t state_next;

  logic                 start_prev;
  logic [NUM_PIPES-1:0] at_col;
  logic [NUM_PIPES-1:0] clear_vec;
  logic [NUM_PIPES-1:0] due;
  logic [NUM_PIPES-1:0] judged;
  logic [NUM_PIPES-1:0] judged_next;
  logic                 judge_en;
  logic                 any_due;
  logic                 any_fail;
  logic                 pass_all;
  logic [HIT_W-1:0]     fail_idx;
  logic [5:0]           clear_cnt;
  logic [SCORE_W+6:0]   score_wide;
  logic [SCORE_W-1:0]   score_sat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
      assign at_col[gi] = (pipe_col[gi*COL_W +: COL_W] == COL_W'(BIRD_COL));
      assign due[gi]    = at_col[gi] && !judged[gi];

      gap_check #(
        .ROW_W(ROW_W),
        .GAP_W(GAP_W)
      ) u_gap_check (
        .bird_pos(bird_pos),
        .gap_base(gap_base[gi*ROW_W +: ROW_W]),
        .gap_size(gap_size[gi*GAP_W +: GAP_W]),
        .clear   (clear_vec[gi])
      );
    end
  endgenerate

  // Out-of-bounds outranks any pipe judgement in the same cycle.
  assign judge_en = (state == PLAY) && !OFB;
  assign any_due  = |due;
  assign any_fail = |(due & ~clear_vec);
  assign pass_all = judge_en && any_due && !any_fail;

  // A pipe stays judged for as long as it sits in the bird column.
  assign judged_next = at_col & (judged | (due & {NUM_PIPES{judge_en}}));

  always_comb begin
    fail_idx = '0;
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      if (due[i] && !clear_vec[i]) begin
        fail_idx = HIT_W'(i);
      end
    end
  end

  assign clear_cnt  = popcount(32'(due));
  assign score_wide = {7'b0, score} + {{(SCORE_W+1){1'b0}}, clear_cnt};
  assign score_sat  = (score_wide > {7'b0, {SCORE_W{1'b1}}}) ? {SCORE_W{1'b1}}
                                                             : score_wide[SCORE_W-1:0];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PLAY;
      PLAY:    if (OFB || any_fail) state_next = OVER;
      OVER:    if (start && !start_prev) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      start_prev <= 1'b0;
      increment  <= 1'b0;
      score      <= '0;
      hit_pipe   <= '0;
      judged     <= '0;
    end else begin
      start_prev <= start;
      increment  <= pass_all;
      judged     <= judged_next;
      if (state == IDLE && start) begin
        score <= '0;
      end else if (pass_all) begin
        score <= score_sat;
      end
      if (judge_en && any_fail) begin
        hit_pipe <= fail_idx;
      end
    end
  end

  assign game_over = (state == OVER);

`ifdef PIPE_JUDGE_BEST_SCORE_EN
  logic [SCORE_W-1:0] best_reg;

  // Games end only on a fail or OFB, neither of which scores, so score is final here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      best_reg <= '0;
    end else if (state == PLAY && state_next == OVER && score > best_reg) begin
      best_reg <= score;
    end
  end

  assign best_score = best_reg;
`else
  assign best_score = '0;
`endif

endmodule

// File: tb/tb_pipe_judge.sv
// Self-checking bench for pipe_judge: directed vector table, corner sequences, random run vs model.
module tb_pipe_judge;

  logic       clock;
  logic       reset;
  logic       start;
  logic       ofb;
  logic [3:0] bird;
  logic [7:0] pipe_col;
  logic [7:0] gap_base;
  logic [5:0] gap_size;
  logic       increment;
  logic       game_over;
  logic [7:0] score;
  logic [0:0] hit_pipe;
  logic [7:0] best_score;

  int tests = 0;
  int fails = 0;

  pipe_judge #(
    .NUM_PIPES(2), .ROW_W(4), .GAP_W(3), .COL_W(4), .BIRD_COL(8), .SCORE_W(8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bird_pos  (bird),
    .OFB       (ofb),
    .pipe_col  (pipe_col),
    .gap_base  (gap_base),
    .gap_size  (gap_size),
    .increment (increment),
    .game_over (game_over),
    .score     (score),
    .hit_pipe  (hit_pipe),
    .best_score(best_score)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic st;
    logic of;
    int   b;
    int   c0, b0, s0;
    int   c1, b1, s1;
    logic inc;
    logic go;
    int   sc;
    int   hit;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input logic st, of, input int b, c0, b0, s0, c1, b1, s1,
                              input logic inc, go, input int sc, hit);
    vec_t v;
    v.st = st; v.of = of; v.b = b;
    v.c0 = c0; v.b0 = b0; v.s0 = s0;
    v.c1 = c1; v.b1 = b1; v.s1 = s1;
    v.inc = inc; v.go = go; v.sc = sc; v.hit = hit;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, of, input int b, c0, b0, s0, c1, b1, s1);
    start    = st;
    ofb      = of;
    bird     = 4'(b);
    pipe_col = {4'(c1), 4'(c0)};
    gap_base = {4'(b1), 4'(b0)};
    gap_size = {3'(s1), 3'(s0)};
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
  endtask

  // Behavioural model state for the random run.
  int m_state;   // 0 idle, 1 play, 2 over
  int m_score, m_hit, m_inc, m_best;
  bit m_judged[2];
  bit m_prev;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("reset increment", 32'(increment), 0);
    chk("reset game_over", 32'(game_over), 0);
    chk("reset score", 32'(score), 0);
    chk("reset hit_pipe", 32'(hit_pipe), 0);
    chk("reset best_score", 32'(best_score), 0);
    reset = 1'b0;

    //            st of  b  c0 b0 s0 c1 b1 s1  inc go sc hit
    tbl[0]  = mk(1, 0,  3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[1]  = mk(1, 0,  3, 8, 2, 4, 0, 0, 0,  1, 0, 1, 0);
    tbl[2]  = mk(1, 0,  3, 8, 2, 4, 0, 0, 0,  0, 0, 1, 0);
    tbl[3]  = mk(1, 0,  3, 8, 2, 4, 0, 0, 0,  0, 0, 1, 0);
    tbl[4]  = mk(1, 0,  3, 8, 2, 4, 0, 0, 0,  0, 0, 1, 0);
    tbl[5]  = mk(1, 0,  3, 8, 2, 4, 0, 0, 0,  0, 0, 1, 0);
    tbl[6]  = mk(1, 0,  3, 0, 2, 4, 0, 0, 0,  0, 0, 1, 0);
    tbl[7]  = mk(1, 0,  3, 8, 0, 4, 8, 3, 4,  1, 0, 3, 0);
    tbl[8]  = mk(1, 0,  3, 0, 0, 4, 0, 3, 4,  0, 0, 3, 0);
    tbl[9]  = mk(1, 0, 15, 8,14, 7, 0, 0, 0,  1, 0, 4, 0);
    tbl[10] = mk(1, 0, 15, 0,14, 7, 0, 0, 0,  0, 0, 4, 0);
    tbl[11] = mk(1, 0,  6, 8, 2, 4, 0, 0, 0,  0, 1, 4, 0);
    tbl[12] = mk(0, 0,  6, 0, 2, 4, 0, 0, 0,  0, 1, 4, 0);
    tbl[13] = mk(1, 0,  6, 0, 2, 4, 0, 0, 0,  0, 0, 4, 0);
    tbl[14] = mk(1, 0,  3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[15] = mk(1, 0,  3, 8, 3, 0, 0, 0, 0,  0, 1, 0, 0);
    tbl[16] = mk(0, 0,  3, 0, 3, 0, 0, 0, 0,  0, 1, 0, 0);
    tbl[17] = mk(1, 0,  3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[18] = mk(1, 0,  3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[19] = mk(1, 0,  3, 8, 2, 4, 0, 0, 0,  1, 0, 1, 0);
    tbl[20] = mk(1, 0,  3, 0, 2, 4, 0, 0, 0,  0, 0, 1, 0);
    tbl[21] = mk(1, 0,  3, 8, 0, 4, 8, 5, 4,  0, 1, 1, 1);
    tbl[22] = mk(0, 0,  3, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1);
    tbl[23] = mk(1, 0,  3, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0);
    tbl[24] = mk(1, 0,  3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[25] = mk(1, 1,  3, 8, 2, 4, 0, 0, 0,  0, 1, 0, 1);
    tbl[26] = mk(0, 0,  3, 0, 2, 4, 0, 0, 0,  0, 1, 0, 1);
    tbl[27] = mk(1, 0,  3, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    tbl[28] = mk(0, 0,  3, 8, 2, 4, 0, 0, 0,  0, 0, 0, 0);

    for (int r = 0; r < 29; r++) begin
      drive(tbl[r].st, tbl[r].of, tbl[r].b, tbl[r].c0, tbl[r].b0, tbl[r].s0,
            tbl[r].c1, tbl[r].b1, tbl[r].s1);
      tick();
      chk($sformatf("row%0d increment", r), 32'(increment), 32'(tbl[r].inc));
      chk($sformatf("row%0d game_over", r), 32'(game_over), 32'(tbl[r].go));
      chk($sformatf("row%0d score", r), 32'(score), 32'(tbl[r].sc));
      if (tbl[r].go) chk($sformatf("row%0d hit_pipe", r), 32'(hit_pipe), 32'(tbl[r].hit));
`ifndef PIPE_JUDGE_BEST_SCORE_EN
      chk($sformatf("row%0d best_score", r), 32'(best_score), 0);
`endif
    end

    // Saturation: 127 double clears reach 254, one more single gives 255, then holds.
    do_reset();
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 127; k++) begin
      drive(1, 0, 3, 8, 0, 4, 8, 3, 4);
      tick();
      drive(1, 0, 3, 0, 0, 4, 0, 3, 4);
      tick();
    end
    chk("sat score 254", 32'(score), 254);
    drive(1, 0, 3, 8, 0, 4, 0, 3, 4);
    tick();
    chk("sat score 255", 32'(score), 255);
    drive(1, 0, 3, 0, 0, 4, 0, 3, 4);
    tick();
    drive(1, 0, 3, 8, 0, 4, 8, 3, 4);
    tick();
    chk("sat increment", 32'(increment), 1);
    chk("sat score hold", 32'(score), 255);

    // Asynchronous reset in the middle of a cycle during play.
    do_reset();
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, 0, 3, 0, 2, 4, 0, 0, 0);
      tick();
      drive(1, 0, 3, 8, 2, 4, 0, 0, 0);
      tick();
    end
    chk("pre-reset score", 32'(score), 5);
    chk("pre-reset increment", 32'(increment), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async score", 32'(score), 0);
    chk("async increment", 32'(increment), 0);
    chk("async game_over", 32'(game_over), 0);
    chk("async hit_pipe", 32'(hit_pipe), 0);
    chk("async best_score", 32'(best_score), 0);
    tick();
    reset = 1'b0;
    drive(0, 0, 3, 8, 2, 4, 0, 0, 0);
    tick();
    chk("idle ignores pipe score", 32'(score), 0);
    chk("idle ignores pipe inc", 32'(increment), 0);
    drive(1, 0, 3, 8, 2, 4, 0, 0, 0);
    tick();
    tick();
    chk("post-reset first judge", 32'(score), 1);

`ifdef PIPE_JUDGE_BEST_SCORE_EN
    do_reset();
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1, 0, 3, 8, 0, 4, 8, 3, 4); tick();
    drive(1, 0, 3, 0, 0, 4, 0, 3, 4); tick();
    drive(1, 0, 3, 8, 0, 4, 0, 3, 4); tick();
    drive(1, 0, 3, 0, 0, 4, 0, 3, 4); tick();
    drive(1, 1, 3, 0, 0, 4, 0, 3, 4); tick();
    chk("best after 3", 32'(best_score), 3);
    drive(0, 0, 3, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0); tick();
    tick();
    drive(1, 0, 3, 8, 2, 4, 0, 0, 0); tick();
    drive(1, 1, 3, 0, 2, 4, 0, 0, 0); tick();
    chk("second game score", 32'(score), 1);
    chk("best kept 3", 32'(best_score), 3);
    #2;
    reset = 1'b1;
    #1;
    chk("best cleared by reset", 32'(best_score), 0);
    tick();
    reset = 1'b0;
`endif

    // Random run against a behavioural model.
    do_reset();
    m_state = 0; m_score = 0; m_hit = 0; m_inc = 0; m_best = 0;
    m_judged[0] = 0; m_judged[1] = 0; m_prev = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int   cols[2], bases[2], sizes[2];
      int   b, n_due, first_fail;
      logic st, of;
      bit   judging;
      st = ($urandom_range(0, 3) == 0);
      of = ($urandom_range(0, 39) == 0);
      b  = $urandom_range(0, 15);
      for (int i = 0; i < 2; i++) begin
        cols[i]  = $urandom_range(6, 9);
        bases[i] = $urandom_range(0, 15);
        sizes[i] = $urandom_range(0, 7);
      end
      drive(st, of, b, cols[0], bases[0], sizes[0], cols[1], bases[1], sizes[1]);

      n_due = 0;
      first_fail = -1;
      judging = (m_state == 1) && !of;
      for (int i = 0; i < 2; i++) begin
        if (cols[i] == 8 && !m_judged[i]) begin
          n_due++;
          if (!(b >= bases[i] && b < bases[i] + sizes[i]) && first_fail < 0) first_fail = i;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (cols[i] != 8) m_judged[i] = 0;
        else if (judging) m_judged[i] = 1;
      end
      m_inc = 0;
      case (m_state)
        0: if (st) begin m_state = 1; m_score = 0; end
        1: begin
          if (of || first_fail >= 0) begin
            m_state = 2;
            if (!of) m_hit = first_fail;
            if (m_score > m_best) m_best = m_score;
          end else if (n_due > 0) begin
            m_score = (m_score + n_due > 255) ? 255 : m_score + n_due;
            m_inc = 1;
          end
        end
        default: if (st && !m_prev) m_state = 0;
      endcase
      m_prev = st;

      tick();
      chk($sformatf("rand%0d increment", cyc), 32'(increment), 32'(m_inc));
      chk($sformatf("rand%0d game_over", cyc), 32'(game_over), 32'(m_state == 2));
      chk($sformatf("rand%0d score", cyc), 32'(score), 32'(m_score));
      if (m_state == 2) chk($sformatf("rand%0d hit_pipe", cyc), 32'(hit_pipe), 32'(m_hit));
`ifdef PIPE_JUDGE_BEST_SCORE_EN
      chk($sformatf("rand%0d best_score", cyc), 32'(best_score), 32'(m_best));
`else
      chk($sformatf("rand%0d best_score", cyc), 32'(best_score), 0);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
